// File: rtl/i2s_dac_tx_if.sv
// Sample bus from the last effect stage plus the I2S pins toward the codec DAC.
// master: the upstream stage / codec side; slave: the transmitter.
interface i2s_dac_tx_if;
  logic signed [31:0] in_L;
  logic signed [31:0] in_R;
  logic               mute;
  logic               sample_strobe;
  logic               short_frame;
  logic               AUD_BCLK;
  logic               AUD_DACLRCK;
  logic               AUD_DACDAT;

  modport master (
    output in_L, in_R, mute, AUD_BCLK, AUD_DACLRCK,
    input  sample_strobe, short_frame, AUD_DACDAT
  );

  modport slave (
    input  in_L, in_R, mute, AUD_BCLK, AUD_DACLRCK,
    output sample_strobe, short_frame, AUD_DACDAT
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S slave transmitter: the codec owns BCLK/LRCK. Both are resynchronised into
// CLOCK_50, a stereo pair is latched at each left boundary and shifted out
// MSB-first with the one-bit I2S delay.
module i2s_dac_tx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  i2s_dac_tx_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  // Internal reset: asserts with reset_n, releases two clocks later.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrck_sync_q;
  logic                   bclk_dly_q;
  logic                   bclk_s;
  logic                   lrck_s;
  logic                   bclk_rise;
  logic                   bclk_fall;
  logic                   left_bnd;
  logic                   right_bnd;

  state_e state_q, state_d;
  logic   started;

  logic [DATA_WIDTH-1:0] word_l;
  logic [DATA_WIDTH-1:0] word_r;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  lrck_prev_q, lrck_prev_d;
  logic                  dacdat_q, dacdat_d;
  logic                  strobe_q, strobe_d;
  logic                  short_q, short_d;

  // Reset synchroniser: async assert, sync release.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  // Bring the codec clocks into CLOCK_50 and keep one extra BCLK copy for edges.
  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_dly_q  <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], bus.AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], bus.AUD_DACLRCK};
      bclk_dly_q  <= bclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_dly_q;
  assign bclk_fall = ~bclk_s & bclk_dly_q;
  // LRCK is stable at the rising edge, so boundaries are judged only there.
  assign left_bnd  = bclk_rise & ~lrck_s & lrck_prev_q;
  assign right_bnd = bclk_rise & lrck_s & ~lrck_prev_q;

  // Mute and truncation are applied once, as the pair is latched.
  assign word_l = bus.mute ? '0 : bus.in_L[31 -: DATA_WIDTH];
  assign word_r = bus.mute ? '0 : bus.in_R[31 -: DATA_WIDTH];

  // Low sample bits below the transmitted word are deliberately dropped.
  if (DATA_WIDTH < 32) begin : g_trunc
    logic unused_low_bits;
    assign unused_low_bits = ^{bus.in_L[31-DATA_WIDTH:0], bus.in_R[31-DATA_WIDTH:0]};
  end

  // Startup state register: idle until the first left boundary after reset.
  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Startup next state: a right boundary alone never starts transmission.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE && left_bnd) state_d = ST_RUN;
  end

  // Startup output decode.
  always_comb begin
    started = (state_q == ST_RUN);
  end

  // Frame bookkeeping on BCLK rises, serial shifting on BCLK falls.
  always_comb begin
    lrck_prev_d = lrck_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_r_d    = hold_r_q;
    dacdat_d    = dacdat_q;
    short_d     = short_q;
    strobe_d    = 1'b0;
    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      if (left_bnd) begin
        if (started && bit_cnt_q < CNT_FULL) short_d = 1'b1;
        hold_r_d  = word_r;
        shift_d   = word_l;
        bit_cnt_d = '0;
        strobe_d  = 1'b1;
      end else if (right_bnd) begin
        if (started) begin
          if (bit_cnt_q < CNT_FULL) short_d = 1'b1;
          shift_d   = hold_r_q;
          bit_cnt_d = '0;
        end
      end else if (bit_cnt_q < CNT_FULL) begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
    // Zero fill means the line idles low once the word has gone out.
    if (bclk_fall && started) begin
      dacdat_d = shift_q[DATA_WIDTH-1];
      shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
    end
  end

  // Datapath registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      lrck_prev_q <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_r_q    <= '0;
      dacdat_q    <= 1'b0;
      strobe_q    <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      lrck_prev_q <= lrck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_r_q    <= hold_r_d;
      dacdat_q    <= dacdat_d;
      strobe_q    <= strobe_d;
      short_q     <= short_d;
    end
  end

  assign bus.AUD_DACDAT    = dacdat_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.short_frame   = short_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: drives codec-style BCLK/LRCK, models what a codec must
// receive, and pins the model with literal expected words.
module tb_i2s_dac_tx;

  localparam int DW   = 24;
  localparam int SYNC = 2;

  typedef struct packed {
    logic          lr;
    logic [DW-1:0] w;
  } cap_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  i2s_dac_tx_if bus_if ();

  i2s_dac_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .bus      (bus_if.slave)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bit a codec sees at rise q of a half carrying word w (q=1 is the boundary rise).
  function automatic logic bitof(input logic [DW-1:0] w, input int q);
    if (q >= 2 && q <= DW + 1) return w[DW+1-q];
    return 1'b0;
  endfunction

  // ---------------- codec-side model and compare process ----------------
  bit            model_en = 0;
  bit            m_active;
  logic          m_lr_prev;
  logic          m_half_lr;
  int            m_pos;
  logic [DW-1:0] m_word;
  logic [DW-1:0] m_next_r;
  logic [DW-1:0] m_cap;
  bit            m_short;
  int            strobe_at = -1;
  int            cyc = 0;
  logic          bclk_q = 1'b0;
  int            n_strobes = 0;
  cap_t          cap_q[$];

  initial begin
    logic be;
    forever begin
      @(negedge clk);
      cyc++;
      if (model_en) begin
        if (!reset_n) begin
          chk("rst_dacdat", 32'(bus_if.AUD_DACDAT), 32'(0));
          chk("rst_short", 32'(bus_if.short_frame), 32'(0));
          chk("rst_strobe", 32'(bus_if.sample_strobe), 32'(0));
          m_active  = 0;
          m_lr_prev = 1'b0;
          m_pos     = 0;
          m_short   = 0;
          strobe_at = -1;
        end else begin
          chk("strobe", 32'(bus_if.sample_strobe), 32'(cyc == strobe_at));
          if (bus_if.sample_strobe) n_strobes++;
          if (bus_if.AUD_BCLK && !bclk_q) begin
            if (bus_if.AUD_DACLRCK !== m_lr_prev) begin
              be = m_active ? bitof(m_word, m_pos + 1) : 1'b0;
              chk("dacdat_boundary", 32'(bus_if.AUD_DACDAT), 32'(be));
              if (m_active) begin
                if (m_pos < DW + 1) m_short = 1;
                cap_q.push_back('{lr: m_half_lr, w: m_cap});
              end
              m_lr_prev = bus_if.AUD_DACLRCK;
              if (!bus_if.AUD_DACLRCK) begin
                m_active  = 1;
                m_word    = bus_if.mute ? '0 : bus_if.in_L[31 -: DW];
                m_next_r  = bus_if.mute ? '0 : bus_if.in_R[31 -: DW];
                strobe_at = cyc + SYNC + 1;
              end else if (m_active) begin
                m_word = m_next_r;
              end
              m_half_lr = bus_if.AUD_DACLRCK;
              m_cap     = '0;
              m_pos     = 1;
            end else begin
              m_pos++;
              be = m_active ? bitof(m_word, m_pos) : 1'b0;
              chk("dacdat_bit", 32'(bus_if.AUD_DACDAT), 32'(be));
              if (m_active && m_pos >= 2 && m_pos <= DW + 1) m_cap[DW+1-m_pos] = bus_if.AUD_DACDAT;
            end
          end
          if (!bus_if.AUD_BCLK && bclk_q) chk("short_frame", 32'(bus_if.short_frame), 32'(m_short));
        end
      end
      bclk_q = bus_if.AUD_BCLK;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pend_L, pend_R;
  logic        pend_mute;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset_n  = 1'b0;
    model_en = 1;
    #1;
    chk("reset_dacdat", 32'(bus_if.AUD_DACDAT), 32'(0));
    chk("reset_short", 32'(bus_if.short_frame), 32'(0));
    chk("reset_strobe", 32'(bus_if.sample_strobe), 32'(0));
    repeat (3) tick;
    reset_n = 1'b1;
    repeat (4) tick;
  endtask

  // One LRCK half of nb BCLK periods (8 clocks per phase). act 1 applies the
  // pending inputs, act 2 pulses reset for 3 clocks, both during bit act_bit.
  task automatic half(input logic lr, input int nb, input int act_bit, input int act);
    for (int i = 0; i < nb; i++) begin
      tick;
      bus_if.AUD_BCLK = 1'b0;
      if (i == 0) bus_if.AUD_DACLRCK = lr;
      repeat (7) tick;
      tick;
      bus_if.AUD_BCLK = 1'b1;
      for (int k = 0; k < 7; k++) begin
        tick;
        if (i == act_bit && act == 1 && k == 1) begin
          bus_if.in_L = pend_L;
          bus_if.in_R = pend_R;
          bus_if.mute = pend_mute;
        end
        if (i == act_bit && act == 2 && k == 1) begin
          reset_n = 1'b0;
          #1;
          chk("midframe_rst_dacdat", 32'(bus_if.AUD_DACDAT), 32'(0));
          chk("midframe_rst_short", 32'(bus_if.short_frame), 32'(0));
        end
        if (i == act_bit && act == 2 && k == 4) reset_n = 1'b1;
      end
    end
  endtask

  task automatic expect_cap(input string nm, input logic lr, input logic [DW-1:0] w);
    cap_t c;
    if (cap_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no word captured, expected lr=%0d word=0x%06h", nm, lr, w);
    end else begin
      c = cap_q.pop_front();
      $display("cap %s lr=%0d word=0x%06h", nm, c.lr, c.w);
      chk(nm, {7'b0, c.lr, c.w}, {7'b0, lr, w});
    end
  endtask

  initial begin
    bus_if.in_L        = 32'h12345678;
    bus_if.in_R        = 32'h80000000;
    bus_if.mute        = 1'b0;
    bus_if.AUD_BCLK    = 1'b0;
    bus_if.AUD_DACLRCK = 1'b1;
    pend_L    = 32'h12345678;
    pend_R    = 32'h80000000;
    pend_mute = 1'b0;
    tick;

    // Right half first after reset, then normal frames, input change, mute.
    do_reset;
    n_strobes = 0;
    half(1, 32, -1, 0);
    chk("no_strobe_before_left", 32'(n_strobes), 32'(0));
    half(0, 32, -1, 0); half(1, 32, -1, 0);
    half(0, 32, -1, 0); half(1, 32, -1, 0);
    pend_L = 32'hFFFFFFFF;
    half(0, 32, 10, 1); half(1, 32, -1, 0);
    pend_mute = 1'b1;
    half(0, 32, -1, 0); half(1, 32, 10, 1);
    pend_mute = 1'b0;
    half(0, 32, 10, 1); half(1, 32, -1, 0);
    half(0, 32, -1, 0); half(1, 32, -1, 0);
    half(0, 32, -1, 0);
    expect_cap("f1_left", 1'b0, 24'h123456);
    expect_cap("f1_right", 1'b1, 24'h800000);
    expect_cap("f2_left", 1'b0, 24'h123456);
    expect_cap("f2_right", 1'b1, 24'h800000);
    expect_cap("chg_cur_left", 1'b0, 24'h123456);
    expect_cap("chg_cur_right", 1'b1, 24'h800000);
    expect_cap("chg_next_left", 1'b0, 24'hFFFFFF);
    expect_cap("mute_cur_right", 1'b1, 24'h800000);
    expect_cap("mute_left", 1'b0, 24'h000000);
    expect_cap("mute_right", 1'b1, 24'h000000);
    expect_cap("unmute_left", 1'b0, 24'hFFFFFF);
    expect_cap("unmute_right", 1'b1, 24'h800000);
    chk("strobes_per_frame", 32'(n_strobes), 32'(7));
    chk("no_short_full_frames", 32'(bus_if.short_frame), 32'(0));
    cap_q.delete();

    // Short halves: 16 BCLK per half with a 24-bit word.
    bus_if.in_L = 32'h12345678;
    bus_if.in_R = 32'h80000000;
    do_reset;
    n_strobes = 0;
    half(1, 16, -1, 0);
    half(0, 16, -1, 0); half(1, 16, -1, 0);
    half(0, 16, -1, 0);
    expect_cap("short_left", 1'b0, 24'h123400);
    expect_cap("short_right", 1'b1, 24'h800000);
    chk("short_flag_set", 32'(bus_if.short_frame), 32'(1));
    chk("short_strobes", 32'(n_strobes), 32'(2));

    // Back to full halves, then reset in the middle of a left word.
    n_strobes = 0;
    half(1, 32, -1, 0);
    half(0, 32, -1, 0);
    chk("short_flag_sticky", 32'(bus_if.short_frame), 32'(1));
    half(1, 32, -1, 0);
    half(0, 32, 8, 2);
    half(1, 32, -1, 0);
    half(0, 32, -1, 0); half(1, 32, -1, 0);
    half(0, 32, -1, 0);
    expect_cap("short_tail_left", 1'b0, 24'h123400);
    expect_cap("full_right", 1'b1, 24'h800000);
    expect_cap("pre_rst_left", 1'b0, 24'h123456);
    expect_cap("pre_rst_right", 1'b1, 24'h800000);
    expect_cap("post_rst_left", 1'b0, 24'h123456);
    expect_cap("post_rst_right", 1'b1, 24'h800000);
    chk("post_rst_extra_words", 32'(cap_q.size()), 32'(0));
    chk("post_rst_short", 32'(bus_if.short_frame), 32'(0));
    chk("rst_seg_strobes", 32'(n_strobes), 32'(4));

    repeat (10) tick;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
